// File: rtl/datapath_pkg.sv
// Shared datapath widths and the stage-2 bubble FSM encoding.
package datapath_pkg;

  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned REG_SELECT_WIDTH = 5;
  localparam int unsigned IMM_WIDTH        = 16;
  localparam int unsigned OPCODE_WIDTH     = 6;
  localparam int unsigned CNT_WIDTH        = 16;

  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_BUBBLE = 1'b1;

  typedef enum logic {
    RUN    = ST_RUN,
    BUBBLE = ST_BUBBLE
  } stage_state_e;

endpackage

// File: rtl/operand_bypass.sv
// Forwards the stage-3 write data over a register file read port when the
// write targets the register being read in the same cycle.
module operand_bypass #(
  parameter int unsigned DATA_WIDTH       = datapath_pkg::DATA_WIDTH,
  parameter int unsigned REG_SELECT_WIDTH = datapath_pkg::REG_SELECT_WIDTH
) (
  input  logic [REG_SELECT_WIDTH-1:0] read_select,
  input  logic [DATA_WIDTH-1:0]       read_data,
  input  logic [REG_SELECT_WIDTH-1:0] write_select,
  input  logic [DATA_WIDTH-1:0]       write_data,
  input  logic                        write_enable,
  output logic [DATA_WIDTH-1:0]       operand_c
);

  // Register 0 is an ordinary register, so no zero-select exclusion.
  assign operand_c = (write_enable && (write_select == read_select)) ? write_data : read_data;

endmodule

// File: rtl/s2_operand_stage.sv
// Stage-1/stage-2 pipeline register: writeback bypass, load-use bubble
// insertion with stage-1 stall, downstream hold with operand refresh, flush.
module s2_operand_stage
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = datapath_pkg::DATA_WIDTH,
  parameter int unsigned REG_SELECT_WIDTH = datapath_pkg::REG_SELECT_WIDTH,
  parameter int unsigned IMM_WIDTH        = datapath_pkg::IMM_WIDTH,
  parameter int unsigned CNT_WIDTH        = datapath_pkg::CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        S1_Valid,
  input  logic [OPCODE_WIDTH-1:0]     S1_Opcode,
  input  logic [REG_SELECT_WIDTH-1:0] S1_ReadSelect1,
  input  logic [REG_SELECT_WIDTH-1:0] S1_ReadSelect2,
  input  logic [REG_SELECT_WIDTH-1:0] S1_WriteSelect,
  input  logic                        S1_IsLoad,
  input  logic [IMM_WIDTH-1:0]        S1_Imm,
  input  logic [DATA_WIDTH-1:0]       RF_ReadData1,
  input  logic [DATA_WIDTH-1:0]       RF_ReadData2,
  input  logic [DATA_WIDTH-1:0]       S3_WriteData,
  input  logic [REG_SELECT_WIDTH-1:0] S3_WriteSelect,
  input  logic                        S3_WriteEnable,
  input  logic                        S2_Hold,
  input  logic                        Flush,
  output logic                        S1_Stall,
  output logic                        S2_Valid,
  output logic [OPCODE_WIDTH-1:0]     S2_Opcode,
  output logic [REG_SELECT_WIDTH-1:0] S2_WriteSelect,
  output logic                        S2_IsLoad,
  output logic [DATA_WIDTH-1:0]       S2_Operand1,
  output logic [DATA_WIDTH-1:0]       S2_Operand2,
  output logic [DATA_WIDTH-1:0]       S2_Imm,
  output logic [CNT_WIDTH-1:0]        S2_BubbleCount
);

  localparam int unsigned EXT_WIDTH = DATA_WIDTH - IMM_WIDTH;

  stage_state_e state_q, state_d;

  logic                        valid_q, valid_d;
  logic [OPCODE_WIDTH-1:0]     opcode_q, opcode_d;
  logic [REG_SELECT_WIDTH-1:0] wsel_q, wsel_d;
  logic                        is_load_q, is_load_d;
  logic [REG_SELECT_WIDTH-1:0] rsel1_q, rsel1_d;
  logic [REG_SELECT_WIDTH-1:0] rsel2_q, rsel2_d;
  logic [DATA_WIDTH-1:0]       op1_q, op1_d;
  logic [DATA_WIDTH-1:0]       op2_q, op2_d;
  logic [DATA_WIDTH-1:0]       imm_q, imm_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] op1_next_c;
  logic [DATA_WIDTH-1:0] op2_next_c;
  logic [DATA_WIDTH-1:0] imm_ext_c;
  logic                  luh_c;
  logic                  bubble_c;

  operand_bypass #(
    .DATA_WIDTH      (DATA_WIDTH),
    .REG_SELECT_WIDTH(REG_SELECT_WIDTH)
  ) u_bypass1 (
    .read_select (S1_ReadSelect1),
    .read_data   (RF_ReadData1),
    .write_select(S3_WriteSelect),
    .write_data  (S3_WriteData),
    .write_enable(S3_WriteEnable),
    .operand_c   (op1_next_c)
  );

  operand_bypass #(
    .DATA_WIDTH      (DATA_WIDTH),
    .REG_SELECT_WIDTH(REG_SELECT_WIDTH)
  ) u_bypass2 (
    .read_select (S1_ReadSelect2),
    .read_data   (RF_ReadData2),
    .write_select(S3_WriteSelect),
    .write_data  (S3_WriteData),
    .write_enable(S3_WriteEnable),
    .operand_c   (op2_next_c)
  );

  assign imm_ext_c = {{EXT_WIDTH{S1_Imm[IMM_WIDTH-1]}}, S1_Imm};

  // Load in stage 2 whose destination is a source of the stage-1 instruction.
  assign luh_c = valid_q && is_load_q && S1_Valid &&
                 ((wsel_q == S1_ReadSelect1) || (wsel_q == S1_ReadSelect2));

  // Only a RUN cycle can insert a bubble; hold and flush both pre-empt it.
  assign bubble_c = (state_q == RUN) && luh_c && !S2_Hold && !Flush;

  assign S1_Stall = S2_Hold || (luh_c && !Flush);

  assign S2_Valid       = valid_q;
  assign S2_Opcode      = opcode_q;
  assign S2_WriteSelect = wsel_q;
  assign S2_IsLoad      = is_load_q;
  assign S2_Operand1    = op1_q;
  assign S2_Operand2    = op2_q;
  assign S2_Imm         = imm_q;
  assign S2_BubbleCount = cnt_q;

  // State and stage-2 register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      wsel_q    <= '0;
      is_load_q <= 1'b0;
      rsel1_q   <= '0;
      rsel2_q   <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      imm_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      wsel_q    <= wsel_d;
      is_load_q <= is_load_d;
      rsel1_q   <= rsel1_d;
      rsel2_q   <= rsel2_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      imm_q     <= imm_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state: flush > hold (with refresh) > bubble > capture.
  always_comb begin
    state_d   = RUN;
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    wsel_d    = wsel_q;
    is_load_d = is_load_q;
    rsel1_d   = rsel1_q;
    rsel2_d   = rsel2_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    imm_d     = imm_q;
    cnt_d     = cnt_q;

    case (state_q)
      RUN:     state_d = bubble_c ? BUBBLE : RUN;
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase

    if (Flush) begin
      valid_d = 1'b0;
    end else if (S2_Hold) begin
      // Held operands must track writebacks they would otherwise miss.
      if (S3_WriteEnable && (S3_WriteSelect == rsel1_q)) op1_d = S3_WriteData;
      if (S3_WriteEnable && (S3_WriteSelect == rsel2_q)) op2_d = S3_WriteData;
    end else if (bubble_c) begin
      valid_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      valid_d   = S1_Valid;
      opcode_d  = S1_Opcode;
      wsel_d    = S1_WriteSelect;
      is_load_d = S1_IsLoad;
      rsel1_d   = S1_ReadSelect1;
      rsel2_d   = S1_ReadSelect2;
      op1_d     = op1_next_c;
      op2_d     = op2_next_c;
      imm_d     = imm_ext_c;
    end
  end

endmodule

// File: tb/tb_s2_operand_stage.sv
// Self-checking bench for s2_operand_stage: directed scenarios plus random
// traffic against a behavioural model of the stage-2 contents.
`timescale 1ns/1ps
module tb_s2_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s1_valid;
  logic [5:0]  s1_opcode;
  logic [4:0]  s1_rs1, s1_rs2, s1_ws;
  logic        s1_isload;
  logic [15:0] s1_imm;
  logic [31:0] rf1, rf2, s3_wd;
  logic [4:0]  s3_ws;
  logic        s3_we, hold, flush;

  logic        stall, valid, isload;
  logic [5:0]  opcode;
  logic [4:0]  ws;
  logic [31:0] op1, op2, imm;
  logic [15:0] cnt;

  logic        stall2, valid2, isload2;
  logic [5:0]  opcode2;
  logic [4:0]  ws2;
  logic [31:0] op1_2, op2_2, imm2;
  logic [1:0]  cnt2;

  // Expected stage-2 contents
  logic        m_valid, m_isload;
  logic [5:0]  m_opcode;
  logic [4:0]  m_ws, m_rs1, m_rs2;
  logic [31:0] m_op1, m_op2, m_imm;
  int          m_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  s2_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .S1_Valid(s1_valid), .S1_Opcode(s1_opcode),
    .S1_ReadSelect1(s1_rs1), .S1_ReadSelect2(s1_rs2), .S1_WriteSelect(s1_ws),
    .S1_IsLoad(s1_isload), .S1_Imm(s1_imm), .RF_ReadData1(rf1), .RF_ReadData2(rf2),
    .S3_WriteData(s3_wd), .S3_WriteSelect(s3_ws), .S3_WriteEnable(s3_we),
    .S2_Hold(hold), .Flush(flush), .S1_Stall(stall), .S2_Valid(valid),
    .S2_Opcode(opcode), .S2_WriteSelect(ws), .S2_IsLoad(isload),
    .S2_Operand1(op1), .S2_Operand2(op2), .S2_Imm(imm), .S2_BubbleCount(cnt)
  );

  s2_operand_stage #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .S1_Valid(s1_valid), .S1_Opcode(s1_opcode),
    .S1_ReadSelect1(s1_rs1), .S1_ReadSelect2(s1_rs2), .S1_WriteSelect(s1_ws),
    .S1_IsLoad(s1_isload), .S1_Imm(s1_imm), .RF_ReadData1(rf1), .RF_ReadData2(rf2),
    .S3_WriteData(s3_wd), .S3_WriteSelect(s3_ws), .S3_WriteEnable(s3_we),
    .S2_Hold(hold), .Flush(flush), .S1_Stall(stall2), .S2_Valid(valid2),
    .S2_Opcode(opcode2), .S2_WriteSelect(ws2), .S2_IsLoad(isload2),
    .S2_Operand1(op1_2), .S2_Operand2(op2_2), .S2_Imm(imm2), .S2_BubbleCount(cnt2)
  );

  function automatic logic exp_luh();
    return m_valid && m_isload && s1_valid && (m_ws == s1_rs1 || m_ws == s1_rs2);
  endfunction

  function automatic logic exp_stall();
    return hold || (exp_luh() && !flush);
  endfunction

  function automatic logic [15:0] exp_cnt16();
    return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
  endfunction

  function automatic logic [1:0] exp_cnt2();
    return (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_isload = 0; m_opcode = 0; m_ws = 0; m_rs1 = 0; m_rs2 = 0;
    m_op1 = 0; m_op2 = 0; m_imm = 0; m_cnt = 0;
  endtask

  task automatic idle_inputs();
    s1_valid = 0; s1_opcode = 0; s1_rs1 = 0; s1_rs2 = 0; s1_ws = 0; s1_isload = 0;
    s1_imm = 0; rf1 = 0; rf2 = 0; s3_wd = 0; s3_ws = 0; s3_we = 0; hold = 0; flush = 0;
  endtask

  task automatic drive_instr(input logic v, input logic [5:0] opc, input logic [4:0] a,
                             input logic [4:0] b, input logic [4:0] d, input logic ld,
                             input logic [15:0] im, input logic [31:0] d1, input logic [31:0] d2);
    s1_valid = v; s1_opcode = opc; s1_rs1 = a; s1_rs2 = b; s1_ws = d; s1_isload = ld;
    s1_imm = im; rf1 = d1; rf2 = d2;
  endtask

  // Advance one rising edge; the model applies the stage rules to the pre-edge inputs.
  task automatic tick();
    if (flush) begin
      m_valid = 0;
    end else if (hold) begin
      if (s3_we && s3_ws == m_rs1) m_op1 = s3_wd;
      if (s3_we && s3_ws == m_rs2) m_op2 = s3_wd;
    end else if (exp_luh()) begin
      m_valid = 0;
      m_cnt   = m_cnt + 1;
    end else begin
      m_valid = s1_valid; m_opcode = s1_opcode; m_ws = s1_ws; m_isload = s1_isload;
      m_rs1 = s1_rs1; m_rs2 = s1_rs2;
      m_op1 = (s3_we && s3_ws == s1_rs1) ? s3_wd : rf1;
      m_op2 = (s3_we && s3_ws == s1_rs2) ? s3_wd : rf2;
      m_imm = 32'($signed(s1_imm));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({valid, isload, opcode, ws, op1, op2, imm, cnt} !== '0)
      $display("FAIL reset_state got v=%0b op1=%h imm=%h cnt=%0d want all zero", valid, op1, imm, cnt);
    else passed++;
    total++;
    if (stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall); else passed++;
    hold = 1; #1;
    total++;
    if (stall !== 1'b1) $display("FAIL reset_stall_hold got %0b want 1", stall); else passed++;
    hold = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_capture();
    idle_inputs();
    drive_instr(1, 6'h23, 5'd1, 5'd2, 5'd4, 0, 16'h8001, 32'hDEADBEEF, 32'h12345678);
    tick();
    total++;
    if (op1 !== 32'hDEADBEEF) $display("FAIL capture_op1 got %h want deadbeef", op1); else passed++;
    total++;
    if (op2 !== 32'h12345678) $display("FAIL capture_op2 got %h want 12345678", op2); else passed++;
    total++;
    if (imm !== 32'hFFFF8001) $display("FAIL capture_imm got %h want ffff8001", imm); else passed++;
    total++;
    if (valid !== 1'b1 || opcode !== 6'h23 || ws !== 5'd4)
      $display("FAIL capture_ctl got v=%0b opc=%h ws=%0d want 1/23/4", valid, opcode, ws);
    else passed++;
  endtask

  task automatic test_bypass();
    idle_inputs();
    drive_instr(1, 6'h01, 5'd5, 5'd6, 5'd8, 0, 16'h0010, 32'h0, 32'h77);
    s3_we = 1; s3_ws = 5'd5; s3_wd = 32'hBADF000D;
    tick();
    total++;
    if (op1 !== 32'hBADF000D) $display("FAIL bypass_on got %h want badf000d", op1); else passed++;
    total++;
    if (imm !== 32'h00000010) $display("FAIL bypass_imm got %h want 00000010", imm); else passed++;
    s3_we = 0;
    tick();
    total++;
    if (op1 !== 32'h0) $display("FAIL bypass_off got %h want 0", op1); else passed++;
    // Register 0 is forwarded like any other register.
    drive_instr(1, 6'h02, 5'd9, 5'd0, 5'd3, 0, 16'h0, 32'h1, 32'h2);
    s3_we = 1; s3_ws = 5'd0; s3_wd = 32'h0BAD0BAD;
    tick();
    total++;
    if (op2 !== 32'h0BAD0BAD || op1 !== 32'h1)
      $display("FAIL bypass_r0 got op1=%h op2=%h want 00000001/0bad0bad", op1, op2);
    else passed++;
  endtask

  task automatic test_load_use();
    idle_inputs();
    tick();
    drive_instr(1, 6'h20, 5'd1, 5'd2, 5'd7, 1, 16'h0, 32'h0, 32'h0);
    tick();
    drive_instr(1, 6'h04, 5'd7, 5'd3, 5'd9, 0, 16'h0, 32'h11111111, 32'h3);
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL luh_stall got %0b want 1", stall); else passed++;
    tick();
    total++;
    if (valid !== 1'b0 || cnt !== 16'd1)
      $display("FAIL luh_bubble got v=%0b cnt=%0d want 0/1", valid, cnt);
    else passed++;
    total++;
    if (stall !== 1'b0) $display("FAIL luh_stall_release got %0b want 0", stall); else passed++;
    tick();
    total++;
    if (valid !== 1'b1 || op1 !== 32'h11111111 || opcode !== 6'h04)
      $display("FAIL luh_capture got v=%0b op1=%h opc=%h want 1/11111111/04", valid, op1, opcode);
    else passed++;
  endtask

  task automatic test_hold_refresh();
    idle_inputs();
    drive_instr(1, 6'h08, 5'd3, 5'd4, 5'd10, 0, 16'h0, 32'hAAAA0000, 32'h4);
    tick();
    hold = 1;
    drive_instr(1, 6'h09, 5'd12, 5'd13, 5'd14, 0, 16'h5, 32'h5555, 32'h6666);
    for (int c = 0; c < 3; c++) begin
      s3_we = (c == 1); s3_ws = 5'd3; s3_wd = 32'hCAFEF00D;
      #1;
      total++;
      if (stall !== 1'b1) $display("FAIL hold_stall cycle %0d got %0b want 1", c, stall); else passed++;
      tick();
      if (c == 0) begin
        total++;
        if (op1 !== 32'hAAAA0000) $display("FAIL hold_keep got %h want aaaa0000", op1); else passed++;
      end
    end
    hold = 0; s3_we = 0;
    total++;
    if (op1 !== 32'hCAFEF00D || opcode !== 6'h08 || valid !== 1'b1)
      $display("FAIL hold_refresh got op1=%h opc=%h want cafef00d/08", op1, opcode);
    else passed++;
  endtask

  task automatic test_flush_priority();
    for (int h = 0; h < 2; h++) begin
      int c0;
      idle_inputs();
      tick();
      drive_instr(1, 6'h20, 5'd1, 5'd1, 5'd9, 1, 16'h0, 32'h0, 32'h0);
      tick();
      c0 = m_cnt;
      drive_instr(1, 6'h05, 5'd2, 5'd9, 5'd11, 0, 16'h0, 32'h1, 32'h2);
      flush = 1; hold = logic'(h);
      #1;
      total++;
      if (stall !== logic'(h)) $display("FAIL flush_stall hold=%0d got %0b want %0d", h, stall, h); else passed++;
      tick();
      total++;
      if (valid !== 1'b0 || cnt !== 16'(c0))
        $display("FAIL flush_state hold=%0d got v=%0b cnt=%0d want 0/%0d", h, valid, cnt, c0);
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_instr(logic'($urandom_range(0, 3) != 0), 6'($urandom), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  logic'($urandom_range(0, 9) < 4), 16'($urandom), 32'($urandom), 32'($urandom));
      s3_we = logic'($urandom_range(0, 1)); s3_ws = 5'($urandom_range(0, 3)); s3_wd = 32'($urandom);
      hold  = logic'($urandom_range(0, 9) < 2);
      flush = logic'($urandom_range(0, 9) == 0);
      #1;
      total++;
      if (stall !== exp_stall() || stall2 !== exp_stall())
        $display("FAIL rand_stall i=%0d got %0b/%0b want %0b", i, stall, stall2, exp_stall());
      else passed++;
      tick();
      total++;
      if (valid !== m_valid || isload !== m_isload || opcode !== m_opcode || ws !== m_ws)
        $display("FAIL rand_ctl i=%0d got v=%0b ld=%0b opc=%h ws=%0d want %0b/%0b/%h/%0d",
                 i, valid, isload, opcode, ws, m_valid, m_isload, m_opcode, m_ws);
      else passed++;
      total++;
      if (op1 !== m_op1 || op2 !== m_op2 || imm !== m_imm)
        $display("FAIL rand_data i=%0d got %h %h %h want %h %h %h", i, op1, op2, imm, m_op1, m_op2, m_imm);
      else passed++;
      total++;
      if (cnt !== exp_cnt16() || cnt2 !== exp_cnt2() || valid2 !== m_valid || op1_2 !== m_op1)
        $display("FAIL rand_cnt i=%0d got %0d/%0d want %0d/%0d", i, cnt, cnt2, exp_cnt16(), exp_cnt2());
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_saturation_async_reset();
    idle_inputs();
    tick();
    drive_instr(1, 6'h20, 5'd1, 5'd2, 5'd7, 1, 16'h0, 32'h55, 32'h66);
    tick();
    drive_instr(1, 6'h04, 5'd7, 5'd3, 5'd9, 0, 16'h0, 32'h1, 32'h2);
    tick();
    // Mid-bubble: reset between edges must clear everything at once.
    #2 rst_n = 0;
    #1;
    total++;
    if ({valid, isload, opcode, ws, op1, op2, imm, cnt, cnt2} !== '0)
      $display("FAIL async_reset got v=%0b op1=%h cnt=%0d cnt2=%0d want all zero", valid, op1, cnt, cnt2);
    else passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    tick();
    total++;
    if (valid !== 1'b1 || op1 !== 32'h1 || cnt !== 16'd0)
      $display("FAIL post_reset_run got v=%0b op1=%h cnt=%0d want 1/00000001/0", valid, op1, cnt);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      drive_instr(1, 6'h20, 5'd1, 5'd2, 5'd7, 1, 16'h0, 32'h0, 32'h0);
      tick();
      drive_instr(1, 6'h04, 5'd7, 5'd3, 5'd9, 0, 16'h0, 32'h1, 32'h2);
      tick();
      total++;
      if (cnt !== 16'(i + 1) || cnt2 !== ((i >= 2) ? 2'd3 : 2'(i + 1)))
        $display("FAIL sat_count bubble %0d got %0d/%0d want %0d/%0d", i, cnt, cnt2,
                 i + 1, (i >= 2) ? 3 : i + 1);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_bypass();
    test_load_use();
    test_hold_refresh();
    test_flush_priority();
    test_random();
    test_saturation_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
